// File: rtl/if_fetch_unit.sv
// if_fetch_unit: owns the fetch PC, talks req/gnt/rvalid to instruction memory and
// presents a 2-entry instruction queue head to IF/ID. Redirects kill responses, never requests.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  input  logic        flush,
  input  logic [31:0] new_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        fetch_stallreq
);

  localparam logic [2:0] QD = 3'(QDEPTH);

  logic [31:0] pc, pc_n;
  logic [31:0] q_pc [2];
  logic [31:0] q_inst [2];
  logic [31:0] q_pc_n [2];
  logic [31:0] q_inst_n [2];
  logic [1:0]  cnt, cnt_n;
  logic [31:0] a_addr [2];
  logic [31:0] a_addr_n [2];
  logic [1:0]  a_kill, a_kill_n;
  logic [1:0]  a_cnt, a_cnt_n;
  logic        pop, fire, resp, resp_live, push, keep_one, found;
  logic [2:0]  used;
  logic        unused_stall;

  assign unused_stall = ^stall[5:1];

  // A head popped this edge frees its slot, which keeps a 1-cycle memory at 1 IPC.
  assign pop       = (cnt != 2'd0) && !stall[0] && !flush;
  assign used      = {1'b0, cnt} + {1'b0, a_cnt} - {2'b00, pop};
  assign imem_req  = !rst && (used < QD);
  assign imem_addr = pc;
  assign fire      = imem_req && imem_gnt;
  assign resp      = imem_rvalid && (a_cnt != 2'd0);
  assign resp_live = resp && !a_kill[0];
  assign push      = resp_live && !flush && !(branch_flag_i && (cnt != 2'd0));
  assign keep_one  = branch_flag_i && !flush && (cnt == 2'd0) && !resp_live;

  assign if_pc          = (cnt != 2'd0) ? q_pc[0] : 32'd0;
  assign if_inst        = (cnt != 2'd0) ? q_inst[0] : 32'd0;
  assign fetch_stallreq = (cnt == 2'd0);

  always_comb begin
    pc_n = pc;
    if (flush)              pc_n = new_pc & ~32'h3;
    else if (branch_flag_i) pc_n = branch_target_address_i & ~32'h3;
    else if (fire)          pc_n = pc + 32'd4;
  end

  // On a branch the head is the delay slot: only it survives.
  always_comb begin
    q_pc_n   = q_pc;
    q_inst_n = q_inst;
    cnt_n    = cnt;
    if (pop) begin
      q_pc_n[0]   = q_pc[1];
      q_inst_n[0] = q_inst[1];
      cnt_n       = cnt - 2'd1;
    end
    if (flush)
      cnt_n = 2'd0;
    else if (branch_flag_i && (cnt != 2'd0))
      cnt_n = pop ? 2'd0 : 2'd1;
    if (push) begin
      if (cnt_n == 2'd0) begin
        q_pc_n[0]   = a_addr[0];
        q_inst_n[0] = imem_rdata;
      end else begin
        q_pc_n[1]   = a_addr[0];
        q_inst_n[1] = imem_rdata;
      end
      cnt_n = cnt_n + 2'd1;
    end
  end

  // Outstanding-request FIFO; a set kill bit means the response is dropped on return.
  always_comb begin
    a_addr_n = a_addr;
    a_kill_n = a_kill;
    a_cnt_n  = a_cnt;
    found    = 1'b0;
    if (resp) begin
      a_addr_n[0] = a_addr[1];
      a_kill_n[0] = a_kill[1];
      a_cnt_n     = a_cnt - 2'd1;
    end
    if (fire) begin
      if (a_cnt_n == 2'd0) begin
        a_addr_n[0] = pc;
        a_kill_n[0] = 1'b0;
      end else begin
        a_addr_n[1] = pc;
        a_kill_n[1] = 1'b0;
      end
      a_cnt_n = a_cnt_n + 2'd1;
    end
    if (flush || branch_flag_i) begin
      for (int i = 0; i < 2; i++) begin
        if (i < int'(a_cnt_n)) begin
          if (keep_one && !found && !a_kill_n[i]) found = 1'b1;
          else                                    a_kill_n[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= RESET_PC;
      cnt    <= 2'd0;
      a_cnt  <= 2'd0;
      a_kill <= 2'b00;
    end else begin
      pc     <= pc_n;
      cnt    <= cnt_n;
      a_cnt  <= a_cnt_n;
      a_kill <= a_kill_n;
    end
  end

  always_ff @(posedge clk) begin
    q_pc   <= q_pc_n;
    q_inst <= q_inst_n;
    a_addr <= a_addr_n;
  end

endmodule
